// File: rtl/data_memory_mmio.sv
// Data memory with byte/half/word access, a write-only loader port and a
// memory-mapped UART TX FIFO (push register plus readable status register).
module data_memory_mmio #(
  parameter int          DEPTH          = 12,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] UART_TX_ADDR   = 32'h1000_0000,
  parameter logic [31:0] UART_STAT_ADDR = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [1:0]  bytes,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        misalign,
  input  logic [31:0] addr_b,
  input  logic [31:0] din_b,
  input  logic        we_b,
  output logic [7:0]  uart_tdata,
  output logic        uart_tvalid,
  input  logic        uart_tready
);

  localparam int WORDS        = 2 ** DEPTH;
  localparam int FIFO_ENTRIES = 2 ** FIFO_DEPTH;

  logic [31:0]           r_mem [WORDS];
  logic [7:0]            r_fifo [FIFO_ENTRIES];
  logic [31:0]           r_ram_word;
  logic [31:0]           r_mmio_word;
  logic                  r_src_ram;
  logic [1:0]            r_ld_size;
  logic [1:0]            r_ld_lane;
  logic                  r_ld_unsigned;
  logic                  r_rvalid;
  logic                  r_misalign;
  logic [FIFO_DEPTH-1:0] r_wptr;
  logic [FIFO_DEPTH-1:0] r_rptr;
  logic [FIFO_DEPTH:0]   r_count;
  logic [7:0]            r_tdata;

  logic                  w_is_tx;
  logic                  w_is_stat;
  logic                  w_misalign;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_stall;
  logic                  w_load_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [3:0]            w_be_a;
  logic [31:0]           w_wdata_a;
  logic [DEPTH-1:0]      w_idx_a;
  logic [DEPTH-1:0]      w_idx_b;
  logic [31:0]           w_count_ext;
  logic [7:0]            w_count_sat;
  logic [31:0]           w_stat_word;
  logic [FIFO_DEPTH-1:0] w_rptr_next;
  logic [7:0]            w_head_next;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_ext;
  logic                  w_unused_b;

  assign w_is_tx    = (addr == UART_TX_ADDR);
  assign w_is_stat  = (addr == UART_STAT_ADDR);
  assign w_idx_a    = addr[DEPTH+1:2];
  assign w_idx_b    = addr_b[DEPTH+1:2];
  assign w_unused_b = ^{addr_b[31:DEPTH+2], addr_b[1:0]};

  always_comb begin
    case (bytes)
      2'b01:   w_misalign = 1'b0;
      2'b10:   w_misalign = addr[0];
      default: w_misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // count never exceeds FIFO_ENTRIES, so its MSB alone flags full
  assign w_full      = r_count[FIFO_DEPTH];
  assign w_empty     = (r_count == '0);
  assign w_stall     = we && w_is_tx && !w_misalign && w_full;
  assign w_load_acc  = re && !w_stall;
  assign w_push      = we && w_is_tx && !w_misalign && !w_full;
  assign w_pop       = !w_empty && uart_tready;

  assign w_count_ext = 32'(r_count);
  assign w_count_sat = (w_count_ext > 32'd255) ? 8'hFF : w_count_ext[7:0];
  assign w_stat_word = {16'h0, w_count_sat, 6'h0, w_full, w_empty};

  always_comb begin
    w_be_a    = 4'b0000;
    w_wdata_a = wdata;
    if (we && !w_misalign && !w_is_tx && !w_is_stat) begin
      case (bytes)
        2'b01: begin
          w_be_a    = 4'b0001 << addr[1:0];
          w_wdata_a = {4{wdata[7:0]}};
        end
        2'b10: begin
          w_be_a    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata_a = {2{wdata[15:0]}};
        end
        default: w_be_a = 4'b1111;
      endcase
    end
  end

  // Port B is written after port A so it owns every byte of a shared word
  always_ff @(posedge clk) begin
    if (w_load_acc) r_ram_word <= r_mem[w_idx_a];
    for (int i = 0; i < 4; i++) begin
      if (w_be_a[i]) r_mem[w_idx_a][i*8 +: 8] <= w_wdata_a[i*8 +: 8];
      if (we_b)      r_mem[w_idx_b][i*8 +: 8] <= din_b[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid      <= 1'b0;
      r_misalign    <= 1'b0;
      r_src_ram     <= 1'b0;
      r_mmio_word   <= '0;
      r_ld_size     <= 2'b00;
      r_ld_lane     <= 2'b00;
      r_ld_unsigned <= 1'b0;
    end else begin
      r_rvalid   <= w_load_acc;
      r_misalign <= (re || we) && w_misalign;
      if (w_load_acc) begin
        r_src_ram     <= !w_misalign && !w_is_tx && !w_is_stat;
        r_mmio_word   <= (w_is_stat && !w_misalign) ? w_stat_word : '0;
        r_ld_size     <= bytes;
        r_ld_lane     <= addr[1:0];
        r_ld_unsigned <= is_unsigned;
      end
    end
  end

  always_comb begin
    w_byte = r_ram_word[{r_ld_lane, 3'b000} +: 8];
    w_half = r_ld_lane[1] ? r_ram_word[31:16] : r_ram_word[15:0];
    case (r_ld_size)
      2'b01:   w_ext = {{24{!r_ld_unsigned && w_byte[7]}}, w_byte};
      2'b10:   w_ext = {{16{!r_ld_unsigned && w_half[15]}}, w_half};
      default: w_ext = r_ram_word;
    endcase
  end

  assign rdata    = r_src_ram ? w_ext : r_mmio_word;
  assign rvalid   = r_rvalid;
  assign misalign = r_misalign;
  assign stall    = w_stall;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= wdata[7:0];
  end

  // Head register bypasses the entry being written when it becomes the head
  assign w_rptr_next = w_pop ? r_rptr + FIFO_DEPTH'(1) : r_rptr;
  assign w_head_next = (w_push && (r_wptr == w_rptr_next)) ? wdata[7:0]
                                                           : r_fifo[w_rptr_next];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_tdata <= 8'h00;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_DEPTH'(1);
      r_rptr  <= w_rptr_next;
      r_tdata <= w_head_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign uart_tdata  = r_tdata;
  assign uart_tvalid = !w_empty;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Scoreboard bench for data_memory_mmio: directed scenarios plus random traffic
// checked against a byte-array memory model and a queue model of the TX FIFO.
module tb_data_memory_mmio;

  localparam logic [31:0] TX = 32'h1000_0000;
  localparam logic [31:0] ST = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  bytes = '0;
  logic        is_unsigned = 1'b0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        misalign;
  logic [31:0] addr_b = '0;
  logic [31:0] din_b = '0;
  logic        we_b = 1'b0;
  logic [7:0]  uart_tdata;
  logic        uart_tvalid;
  logic        uart_tready = 1'b0;

  always #5 clk = ~clk;

  data_memory_mmio dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .bytes(bytes),
    .is_unsigned(is_unsigned), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .stall(stall), .misalign(misalign),
    .addr_b(addr_b), .din_b(din_b), .we_b(we_b),
    .uart_tdata(uart_tdata), .uart_tvalid(uart_tvalid), .uart_tready(uart_tready)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        mis;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          tready_mode = 0;
  rsp_t        rsp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  mm [16384];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic bit is_misal(logic [31:0] a, logic [1:0] sz);
    if (nbytes(sz) == 1) return 1'b0;
    if (nbytes(sz) == 2) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic uns);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, mm[int'(a[13:0]) + i]} << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void model_store(logic [31:0] a, int n, logic [31:0] d);
    for (int i = 0; i < n; i++) mm[int'(a[13:0]) + i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_stat();
    int n = tx_q.size();
    logic [7:0] c = (n > 255) ? 8'hFF : 8'(n);
    return {16'h0, c, 6'h0, n == 16, n == 0};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tready_mode == 2) uart_tready = 1'b1;
      else if (tready_mode == 1) uart_tready = 1'($urandom % 2);
      else uart_tready = 1'b0;
    end
  end

  // Response monitor: port A responses and UART handshakes
  initial begin
    rsp_t r;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      #2;
      if (rvalid || misalign) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", {30'h0, rvalid, misalign}, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          $display("rsp rvalid=%0b misalign=%0b rdata=%h", rvalid, misalign, rdata);
          chk("rvalid", {31'h0, rvalid}, {31'h0, r.is_load});
          chk("misalign", {31'h0, misalign}, {31'h0, r.mis});
          if (r.is_load) chk("rdata", rdata, r.data);
        end
      end
      if (uart_tvalid && uart_tready) begin
        if (tx_q.size() == 0) begin
          chk("unexpected_tx", {24'h0, uart_tdata}, 32'h0);
          chk("unexpected_tx_valid", {31'h0, uart_tvalid}, 32'h0);
        end else begin
          b = tx_q.pop_front();
          $display("uart byte %h", uart_tdata);
          chk("uart_tdata", {24'h0, uart_tdata}, {24'h0, b});
        end
      end
    end
  end

  task automatic acc(input logic w, input logic r, input logic [31:0] a,
                     input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                     input logic wb, input logic [31:0] ab, input logic [31:0] db);
    bit ok = 1'b0;
    bit exp_st;
    bit mis;
    rsp_t e;
    we = w; re = r; addr = a; bytes = sz; is_unsigned = uns; wdata = wd;
    we_b = wb; addr_b = ab; din_b = db;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      exp_st = w && (a == TX) && (tx_q.size() >= 16);
      chk("stall", {31'h0, stall}, {31'h0, exp_st});
      if (!exp_st) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: stall=%0b still held after 200 cycles, required release", stall);
    end else begin
      mis = is_misal(a, sz);
      if (r) begin
        e.is_load = 1'b1;
        e.mis = mis;
        if (mis || a == TX) e.data = '0;
        else if (a == ST) e.data = model_stat();
        else e.data = model_load(a, sz, uns);
        rsp_q.push_back(e);
      end else if (w && mis) begin
        e.is_load = 1'b0;
        e.mis = 1'b1;
        e.data = '0;
        rsp_q.push_back(e);
      end
      if (w && !mis) begin
        if (a == TX) tx_q.push_back(wd[7:0]);
        else if (a != ST) model_store(a, nbytes(sz), wd);
      end
      if (wb) model_store({ab[31:2], 2'b00}, 4, db);
      $display("txn we=%0b re=%0b addr=%h bytes=%0d uns=%0b wdata=%h we_b=%0b addr_b=%h din_b=%h",
               w, r, a, sz, uns, wd, wb, ab, db);
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; we_b = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (tx_q.size() > 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    chk("drain_left", tx_q.size(), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] ra = $urandom;
    ra[13:0] = 14'h100 + 14'($urandom % 256);
    return ra;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_tvalid", {31'h0, uart_tvalid}, 32'h0);
    chk("rst_tdata", {24'h0, uart_tdata}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 64; i++) acc(0, 0, 0, 0, 0, 0, 1, 32'h100 + 32'(4 * i), $urandom);

    acc(1, 0, 32'h100, 2'b00, 0, 32'hDEAD_BEEF, 0, 0, 0);
    acc(0, 1, 32'h103, 2'b01, 0, 0, 0, 0, 0);
    acc(0, 1, 32'h103, 2'b01, 1, 0, 0, 0, 0);
    acc(1, 0, 32'h102, 2'b10, 0, 32'h0000_1234, 0, 0, 0);
    acc(0, 1, 32'h100, 2'b00, 0, 0, 0, 0, 0);
    acc(0, 1, 32'h101, 2'b10, 0, 0, 0, 0, 0);
    acc(1, 0, 32'h102, 2'b00, 0, 32'hCAFE_F00D, 0, 0, 0);
    acc(0, 1, 32'h100, 2'b00, 0, 0, 0, 0, 0);
    acc(1, 0, 32'h200, 2'b00, 0, 32'h1111_1111, 1, 32'h200, 32'h2222_2222);
    acc(0, 1, 32'h200, 2'b00, 0, 0, 0, 0, 0);
    acc(1, 1, 32'h104, 2'b00, 0, 32'h5555_AAAA, 0, 0, 0);
    acc(0, 1, 32'h104, 2'b10, 0, 0, 0, 0, 0);

    tready_mode = 0;
    for (int i = 0; i < 16; i++) acc(1, 0, TX, 2'b00, 0, 32'(i), 0, 0, 0);
    acc(0, 1, ST, 2'b00, 0, 0, 0, 0, 0);
    fork
      acc(1, 0, TX, 2'b00, 0, 32'h10, 0, 0, 0);
      begin
        repeat (4) @(posedge clk);
        tready_mode = 2;
      end
    join
    wait_drain();
    tready_mode = 0;

    for (int i = 0; i < 5; i++) acc(1, 0, TX, 2'b01, 0, 32'hA0 + 32'(i), 0, 0, 0);
    tready_mode = 2;
    acc(0, 1, 32'h100, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    chk("tvalid_before_rst", {31'h0, uart_tvalid}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", {31'h0, uart_tvalid}, 32'h0);
    chk("rst_mid_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    rsp_q.delete();
    tx_q.delete();
    tready_mode = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    acc(0, 1, ST, 2'b00, 0, 0, 0, 0, 0);

    tready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom % 10);
      ra = rand_addr();
      rb = rand_addr();
      case (k)
        0, 1, 2: acc(0, 1, ra, 2'($urandom), 1'($urandom), 0, 1'($urandom % 4 == 0), rb, $urandom);
        3, 4, 5: acc(1, 0, ra, 2'($urandom), 1'($urandom), $urandom, 1'($urandom % 4 == 0), rb, $urandom);
        6:       acc(1, 1, ra, 2'($urandom), 1'($urandom), $urandom, 0, rb, $urandom);
        7:       acc(1, 0, TX, 2'($urandom), 0, $urandom, 0, rb, $urandom);
        8:       acc(0, 1, ST, 2'b00, 0, 0, 0, rb, $urandom);
        default: acc(1, 0, ra, 2'b00, 0, $urandom, 1, {ra[31:2], 2'b00}, $urandom);
      endcase
    end

    tready_mode = 2;
    wait_drain();
    repeat (5) @(posedge clk);
    chk("rsp_q_empty", rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Parametrised successor to the core's data memory: word-organised RAM with byte, halfword and word access, and sign/zero extension on loads.
- Registered read path with a read-valid strobe; misaligned-access detection.
- Second write-only port (loader/DMA), plus a memory-mapped UART TX FIFO with ready/valid output and a readable status register.
- Sits between the core load/store unit and the UART transmitter.

Parameters:
- DEPTH, 12, log2 of memory words; word index is addr[DEPTH+1:2].
- FIFO_DEPTH, 4, log2 of UART TX FIFO entries.
- UART_TX_ADDR, 32'h1000_0000, write pushes a byte into the TX FIFO.
- UART_STAT_ADDR, 32'h1000_0004, read returns FIFO status.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- addr  input  32  port A byte address
- bytes  input  2  access size: 00 word, 01 byte, 10 half, 11 treated as word
- is_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads
- wdata  input  32  store data, right-aligned
- we  input  1  port A store
- re  input  1  port A load
- rdata  output  32  load data, registered
- rvalid  output  1  pulses the cycle after an accepted load
- stall  output  1  core must hold the request this cycle
- misalign  output  1  one-cycle pulse after a misaligned access
- addr_b  input  32  port B word address (bits [1:0] ignored)
- din_b  input  32  port B write data
- we_b  input  1  port B full-word write
- uart_tdata  output  8  FIFO head byte
- uart_tvalid  output  1  FIFO non-empty
- uart_tready  input  1  transmitter accepts the head byte

Behaviour:
- Reset (reset_n=0, asynchronous): rdata=0, rvalid=0, misalign=0, FIFO empty (count=0), uart_tvalid=0, uart_tdata=0. RAM contents are not reset.
- Address decode: MMIO uses a full 32-bit compare. Every other address goes to RAM and aliases via addr[DEPTH+1:2].
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Store: no RAM or FIFO effect.
  - Load: rdata=0.
  - Either case: misalign=1 and rvalid=re on the next cycle.
- Load latency: exactly 1 cycle. With re=1 and stall=0 in cycle N, rdata/rvalid are valid in cycle N+1. rdata holds its value until the next accepted load.
- Load lane select: byte lane = addr[1:0]; half lane = addr[1].
- Load extension: is_unsigned=0 replicates bit 7 (byte) or bit 15 (half) into the upper bits; is_unsigned=1 fills with zeros. Word loads are unextended.
- Stores use per-byte write enables: byte writes lane addr[1:0], half writes lanes {addr[1],0}/{addr[1],1}, word writes all lanes. No read-modify-write.
- Load and store to the same word in the same cycle: the load returns the old data (read-before-write).
- Port B vs port A: both write the same word in one cycle → port B wins for all four bytes. Port B has no stall and no MMIO decode.
- UART_TX_ADDR:
  - Store pushes wdata[7:0].
  - Load returns 0.
  - If the FIFO is full, stall=1 combinationally and no push occurs; the core holds we/addr/wdata.
  - Full is evaluated before any same-cycle pop, so a push while full always stalls.
- UART_STAT_ADDR:
  - Load returns {16'h0, count[7:0], 6'h0, full, empty}; count saturates at 255.
  - Stores are ignored with no stall.
- Pop: on uart_tvalid && uart_tready. uart_tdata = head entry, driven from a register.
  - Push to an empty FIFO → uart_tvalid=1 on the next cycle.
  - Simultaneous push and pop when not full or empty → count unchanged, order preserved.
- Pointers are FIFO_DEPTH-bit and wrap modulo 2**FIFO_DEPTH. count is FIFO_DEPTH+1 bits.
- stall is asserted only for a UART TX push while full; it never depends on re alone.
- Reset during a stalled store: the FIFO clears and stall deasserts immediately.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load bytes=01 @0x103 with is_unsigned=0 → rdata=0xFFFFFFDE, rvalid one cycle later; with is_unsigned=1 → 0x000000DE.
- Store half 0x1234 @0x102 over 0xDEADBEEF, then load word @0x100 → 0x1234BEEF.
- Load half @0x101 → misalign=1, rdata=0; store word @0x102 → misalign=1 and the word @0x100 is unchanged.
- With uart_tready=0, push 17 bytes 0x00..0x10 (FIFO_DEPTH=4) → 17th push sees stall=1 and STAT read returns 0x00001002. Then raise uart_tready → bytes drain in order 0x00..0x0F, stall drops, 0x10 is pushed.
- Same cycle: we @0x200 with 0x11111111 and we_b @0x200 with 0x22222222 → later load @0x200 returns 0x22222222.
- Assert reset_n=0 mid-drain with 5 entries queued → uart_tvalid=0 and rvalid=0 immediately; STAT returns 0x00000001 after release.
